// File: rtl/instr_sequencer.sv
// instr_sequencer: program-memory driven instruction source for the processor
// datapath. Words are loaded through a write port while idle, issued one per
// unstalled cycle after start, and the processor's results are captured with a
// fixed latency into a count, a last-result register and a rotate-XOR signature.
module instr_sequencer #(
    parameter int         DEPTH   = 16,
    parameter int         AW      = 4,
    parameter int         RES_LAT = 1,
    parameter logic [5:0] HALT_OP = 6'h3F
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [31:0]   prog_data,
    input  logic          start,
    input  logic          stall,
    input  logic [31:0]   result_in,
    output logic [31:0]   instruction,
    output logic          instr_valid,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   res_count,
    output logic [31:0]   last_result,
    output logic [31:0]   res_sig
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state;
    logic [31:0]   mem [DEPTH];
    logic [31:0]   fetch_word;
    logic          fetch_halt;
    logic          idle_like;
    logic          launch;
    logic          issue;
    // Stage 0 mirrors instr_valid; the tail lines up with the processor's result.
    logic [RES_LAT:0] vld_sr;

    assign fetch_word  = mem[pc];
    assign fetch_halt  = (fetch_word[31:26] == HALT_OP);
    assign idle_like   = (state == S_IDLE) || (state == S_DONE);
    assign launch      = idle_like && start;
    assign issue       = (state == S_RUN) && !stall && !fetch_halt;
    assign instr_valid = vld_sr[0];
    assign busy        = (state == S_RUN) || (state == S_DRAIN);
    assign done        = (state == S_DONE);

    // Program memory write port, open only while no run is in progress.
    // NOTE: the memory array has no reset; it must survive reset and map onto RAM.
    always_ff @(posedge clk) begin
        if (idle_like && prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // Run control: state, fetch pointer and the registered instruction bus.
    // NOTE: all sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            pc          <= '0;
            instruction <= '0;
        end else begin
            instruction <= issue ? fetch_word : '0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state <= S_RUN;
                        pc    <= '0;
                    end
                end
                S_RUN: begin
                    if (!stall) begin
                        if (fetch_halt) begin
                            // HALT is consumed here; pc stays on its address.
                            state <= S_DRAIN;
                        end else begin
                            pc <= pc + AW'(1);
                            if (pc == LAST_ADDR) begin
                                state <= S_DRAIN;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    // Finish once no issued word is still waiting for its result.
                    if (vld_sr == '0) begin
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Result tracking: valid pipeline plus count, last result and signature.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_sr      <= '0;
            res_count   <= '0;
            last_result <= '0;
            res_sig     <= '0;
        end else begin
            vld_sr[0] <= issue;
            for (int i = 1; i <= RES_LAT; i++) begin
                vld_sr[i] <= vld_sr[i-1];
            end
            if (launch) begin
                res_count   <= '0;
                last_result <= '0;
                res_sig     <= '0;
            end else if (vld_sr[RES_LAT]) begin
                last_result <= result_in;
                res_count   <= res_count + (AW + 1)'(1);
                res_sig     <= {res_sig[30:0], res_sig[31]} ^ result_in;
            end
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Testbench for instr_sequencer. A registered processor stand-in returns a
// known function of each valid instruction; expected issue order, counts and
// signatures come from walking a copy of the program memory.
module tb_instr_sequencer;

    localparam int         DEPTH   = 16;
    localparam int         AW      = 4;
    localparam int         RES_LAT = 1;
    localparam logic [5:0] HALT_OP = 6'h3F;
    localparam int         BUDGET  = 200;

    logic          clk = 1'b0;
    logic          reset;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [31:0]   prog_data;
    logic          start;
    logic          stall;
    logic [31:0]   result_in;
    logic [31:0]   instruction;
    logic          instr_valid;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;
    logic [AW:0]   res_count;
    logic [31:0]   last_result;
    logic [31:0]   res_sig;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] exp_q [$];
    logic [31:0] got_q [$];
    logic        v_log [$];
    logic [31:0] i_log [$];
    logic [AW-1:0] pc_log [$];
    int          done_cycle;
    int          both_high;
    logic [AW:0] start_count;

    instr_sequencer #(
        .DEPTH(DEPTH), .AW(AW), .RES_LAT(RES_LAT), .HALT_OP(HALT_OP)
    ) dut (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start), .stall(stall), .result_in(result_in),
        .instruction(instruction), .instr_valid(instr_valid), .pc(pc), .busy(busy),
        .done(done), .res_count(res_count), .last_result(last_result), .res_sig(res_sig)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] proc_fn(input logic [31:0] w);
        return {w[15:0], w[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    // Processor stand-in with one register stage; garbage when nothing is issued.
    always @(posedge clk) begin
        result_in <= instr_valid ? proc_fn(instruction) : $urandom();
    end

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom();
        if (w[31:26] == HALT_OP) w[31:26] = 6'h00;
        return w;
    endfunction

    // Expected issue stream: program words from address 0 up to HALT or end of memory.
    function automatic void build_expect();
        logic [31:0] w;
        exp_q.delete();
        for (int a = 0; a < DEPTH; a++) begin
            w = model_mem[a];
            if (w[31:26] == HALT_OP) break;
            exp_q.push_back(w);
        end
    endfunction

    function automatic logic [31:0] expect_sig();
        logic [31:0] s = '0;
        foreach (exp_q[i]) s = {s[30:0], s[31]} ^ proc_fn(exp_q[i]);
        return s;
    endfunction

    function automatic logic [31:0] expect_last();
        return (exp_q.size() == 0) ? 32'h0 : proc_fn(exp_q[exp_q.size()-1]);
    endfunction

    function automatic void collect_issued();
        got_q.delete();
        foreach (v_log[i]) if (v_log[i] === 1'b1) got_q.push_back(i_log[i]);
    endfunction

    function automatic int bubble_errs();
        int n = 0;
        foreach (v_log[i]) if (v_log[i] !== 1'b1 && i_log[i] !== 32'h0) n++;
        return n;
    endfunction

    task automatic load_word(input int a, input logic [31:0] d);
        prog_we   = 1'b1;
        prog_addr = AW'(a);
        prog_data = d;
        @(negedge clk);
        prog_we = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic load_basic();
        load_word(0, 32'h0001_0001);
        load_word(1, 32'h0001_0002);
        load_word(2, 32'h0400_0001);
        load_word(3, 32'hFC00_0000);
    endtask

    // Pulses start and logs one sample per cycle until done or the cycle budget.
    // Sample c is taken after edge k+c (k = start edge); stall_mask[c] applies to edge k+c+1.
    task automatic do_run(input logic [31:0] stall_mask, input int we_cycle,
                          input logic [31:0] we_data, input bit combo_we,
                          input logic [31:0] combo_data);
        int c;
        v_log.delete(); i_log.delete(); pc_log.delete();
        done_cycle = -1;
        both_high  = 0;
        start = 1'b1;
        if (combo_we) begin
            prog_we   = 1'b1;
            prog_addr = '0;
            prog_data = combo_data;
            model_mem[0] = combo_data;
        end
        @(negedge clk);
        start   = 1'b0;
        prog_we = 1'b0;
        start_count = res_count;
        c = 0;
        while (c < BUDGET && done_cycle < 0) begin
            v_log.push_back(instr_valid);
            i_log.push_back(instruction);
            pc_log.push_back(pc);
            if (busy && done) both_high++;
            if (done) begin
                done_cycle = c;
            end else begin
                stall = (c < 32) ? stall_mask[c] : 1'b0;
                if (c == we_cycle) begin
                    prog_we   = 1'b1;
                    prog_addr = '0;
                    prog_data = we_data;
                end else begin
                    prog_we = 1'b0;
                end
                @(negedge clk);
                c++;
            end
        end
        stall   = 1'b0;
        prog_we = 1'b0;
        collect_issued();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({instruction, instr_valid, pc, busy, done, res_count, last_result, res_sig} !== '0) begin
            n_bad++;
            $display("FAIL reset_hold: instr=%h v=%b pc=%h busy=%b done=%b cnt=%h last=%h sig=%h, all zero required",
                     instruction, instr_valid, pc, busy, done, res_count, last_result, res_sig);
        end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({instruction, instr_valid, pc, busy, done, res_count, last_result, res_sig} !== '0) begin
            n_bad++;
            $display("FAIL reset_idle: instr=%h v=%b pc=%h busy=%b done=%b cnt=%h last=%h sig=%h, all zero required",
                     instruction, instr_valid, pc, busy, done, res_count, last_result, res_sig);
        end
    endtask

    task automatic test_basic();
        load_basic();
        build_expect();
        do_run(32'h0, -1, 32'h0, 1'b0, 32'h0);
        n_cmp++;
        if (done_cycle !== exp_q.size() + RES_LAT + 2) begin
            n_bad++;
            $display("FAIL basic_done_time: done at cycle %0d, required %0d", done_cycle, exp_q.size() + RES_LAT + 2);
        end
        n_cmp++;
        if (v_log[0] !== 1'b0 || v_log[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_first_issue: valid c0=%b c1=%b, required 0 then 1", v_log[0], v_log[1]);
        end
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin
            n_bad++;
            $display("FAIL basic_issue_count: %0d issued, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL basic_word%0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (bubble_errs() !== 0) begin
            n_bad++;
            $display("FAIL basic_idle_bus: %0d non-zero idle cycles, required 0", bubble_errs());
        end
        n_cmp++;
        if ({res_count, res_sig, last_result} !== {5'd3, expect_sig(), expect_last()}) begin
            n_bad++;
            $display("FAIL basic_results: cnt=%0d sig=%h last=%h, required cnt=3 sig=%h last=%h",
                     res_count, res_sig, last_result, expect_sig(), expect_last());
        end
        n_cmp++;
        if (pc !== 4'd3 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_end_state: pc=%0d busy=%b, required pc=3 busy=0", pc, busy);
        end
    endtask

    task automatic test_stall();
        build_expect();
        do_run(32'h2, -1, 32'h0, 1'b0, 32'h0);
        n_cmp++;
        if (v_log[1] !== 1'b1 || i_log[1] !== model_mem[0]) begin
            n_bad++;
            $display("FAIL stall_first: v=%b instr=%h, required 1 %h", v_log[1], i_log[1], model_mem[0]);
        end
        n_cmp++;
        if (v_log[2] !== 1'b0 || i_log[2] !== 32'h0 || pc_log[2] !== 4'd1) begin
            n_bad++;
            $display("FAIL stall_bubble: v=%b instr=%h pc=%0d, required 0 0 1", v_log[2], i_log[2], pc_log[2]);
        end
        n_cmp++;
        if (v_log[3] !== 1'b1 || i_log[3] !== model_mem[1]) begin
            n_bad++;
            $display("FAIL stall_resume: v=%b instr=%h, required 1 %h", v_log[3], i_log[3], model_mem[1]);
        end
        n_cmp++;
        if (res_count !== 5'd3 || done !== 1'b1 || res_sig !== expect_sig()) begin
            n_bad++;
            $display("FAIL stall_results: cnt=%0d done=%b sig=%h, required 3 1 %h", res_count, done, res_sig, expect_sig());
        end
    endtask

    task automatic test_end_of_mem();
        for (int a = 0; a < DEPTH; a++) load_word(a, rand_word());
        build_expect();
        do_run(32'h0, -1, 32'h0, 1'b0, 32'h0);
        n_cmp++;
        if (got_q.size() !== DEPTH) begin
            n_bad++;
            $display("FAIL eom_issue_count: %0d issued, required %0d", got_q.size(), DEPTH);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL eom_word%0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (done_cycle !== DEPTH + RES_LAT + 2) begin
            n_bad++;
            $display("FAIL eom_done_time: done at cycle %0d, required %0d", done_cycle, DEPTH + RES_LAT + 2);
        end
        n_cmp++;
        if ({pc, res_count, res_sig, last_result} !== {4'd0, 5'd16, expect_sig(), expect_last()}) begin
            n_bad++;
            $display("FAIL eom_results: pc=%0d cnt=%0d sig=%h last=%h, required 0 16 %h %h",
                     pc, res_count, res_sig, last_result, expect_sig(), expect_last());
        end
    endtask

    task automatic test_lockout_restart();
        logic [AW:0] first_count;
        load_basic();
        build_expect();
        do_run(32'h0, 1, 32'hDEAD_BEEF, 1'b0, 32'h0);
        first_count = res_count;
        n_cmp++;
        if (first_count !== 5'd3 || done !== 1'b1) begin
            n_bad++;
            $display("FAIL lock_first_run: cnt=%0d done=%b, required 3 1", first_count, done);
        end
        do_run(32'h0, -1, 32'h0, 1'b0, 32'h0);
        n_cmp++;
        if (got_q.size() < 1 || got_q[0] !== 32'h0001_0001) begin
            n_bad++;
            $display("FAIL lock_mem0: first word %h, required 00010001", (got_q.size() > 0) ? got_q[0] : 32'hx);
        end
        n_cmp++;
        if (start_count !== 5'd0) begin
            n_bad++;
            $display("FAIL restart_clear: cnt after start=%0d, required 0", start_count);
        end
        n_cmp++;
        if (res_count !== 5'd3 || res_sig !== expect_sig()) begin
            n_bad++;
            $display("FAIL restart_results: cnt=%0d sig=%h, required 3 %h", res_count, res_sig, expect_sig());
        end
    endtask

    task automatic test_reset_mid_run();
        build_expect();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (instr_valid !== 1'b1 || instruction !== model_mem[1]) begin
            n_bad++;
            $display("FAIL midrst_pre: v=%b instr=%h, required 1 %h", instr_valid, instruction, model_mem[1]);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({busy, instr_valid, instruction, pc, res_count} !== '0) begin
            n_bad++;
            $display("FAIL midrst_async: busy=%b v=%b instr=%h pc=%0d cnt=%0d, all zero required",
                     busy, instr_valid, instruction, pc, res_count);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        do_run(32'h0, -1, 32'h0, 1'b0, 32'h0);
        n_cmp++;
        if (got_q !== exp_q) begin
            n_bad++;
            $display("FAIL midrst_rerun: %0d words issued, first %h, required %0d words first %h",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 32'hx, exp_q.size(), exp_q[0]);
        end
        n_cmp++;
        if (res_count !== 5'd3 || done !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_results: cnt=%0d done=%b, required 3 1", res_count, done);
        end
    endtask

    task automatic test_random();
        int          h;
        bit          combo;
        logic [31:0] w0;
        logic [31:0] mask;
        for (int it = 0; it < 8; it++) begin
            h     = $urandom_range(1, DEPTH);
            combo = 1'($urandom_range(0, 1));
            for (int a = 1; a < DEPTH; a++) begin
                w0 = rand_word();
                if (a == h) w0[31:26] = HALT_OP;
                load_word(a, w0);
            end
            w0 = rand_word();
            if (!combo) load_word(0, w0);
            else model_mem[0] = w0;
            build_expect();
            mask = $urandom() & $urandom();
            do_run(mask, -1, 32'h0, combo, w0);
            n_cmp++;
            if (done_cycle < 0) begin
                n_bad++;
                $display("FAIL rand%0d_timeout: no done within %0d cycles, required done", it, BUDGET);
            end
            n_cmp++;
            if (got_q !== exp_q) begin
                n_bad++;
                $display("FAIL rand%0d_stream: %0d words issued, required %0d (h=%0d combo=%0d)",
                         it, got_q.size(), exp_q.size(), h, combo);
            end
            n_cmp++;
            if ({res_count, res_sig, last_result} !== {5'(exp_q.size()), expect_sig(), expect_last()}) begin
                n_bad++;
                $display("FAIL rand%0d_results: cnt=%0d sig=%h last=%h, required %0d %h %h",
                         it, res_count, res_sig, last_result, exp_q.size(), expect_sig(), expect_last());
            end
            n_cmp++;
            if (pc !== 4'(h) || bubble_errs() !== 0 || both_high !== 0) begin
                n_bad++;
                $display("FAIL rand%0d_misc: pc=%0d idle_errs=%0d busy_and_done=%0d, required pc=%0d 0 0",
                         it, pc, bubble_errs(), both_high, 4'(h));
            end
        end
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        start     = 1'b0;
        stall     = 1'b0;
        for (int a = 0; a < DEPTH; a++) model_mem[a] = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_stall();
        test_end_of_mem();
        test_lockout_restart();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
